// File: rtl/fp32_add_arbiter.sv
// Round-robin arbiter sharing one FP32 adder among NREQ requesters; an in-order tag FIFO
// routes each adder completion back to its requester. Optional stats port: FP32_ARB_STATS_EN.
module fp32_add_arbiter #(
    parameter int NREQ      = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*32-1:0]   req_a_i,
    input  logic [NREQ*32-1:0]   req_b_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic                 add_valid_o,
    output logic [31:0]          add_a_o,
    output logic [31:0]          add_b_o,
    input  logic [31:0]          add_result_i,
    input  logic                 add_done_i,
    input  logic                 add_overflow_i,
    input  logic                 add_underflow_i,
    input  logic                 add_invalid_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [31:0]          rsp_result_o,
    output logic [2:0]           rsp_flags_o,
    input  logic                 flush_i,
    input  logic                 resume_i,
    output logic                 flushed_o,
    output logic                 orphan_err_o
`ifdef FP32_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]   stat_issued_o
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(TAG_DEPTH);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t            state_r, state_nx_s;
    logic [CW-1:0]     count_r, count_nx_s;
    logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [IW-1:0]     tag_mem_r [TAG_DEPTH];
    logic [IW-1:0]     last_r;
    logic [IW-1:0]     grant_idx_s, cand_s, head_tag_s;
    logic [NREQ-1:0]   grant_s, rsp_onehot_s;
    logic              found_s, grant_en_s, accept_s, pop_s, orphan_s;
    logic [31:0]       sel_a_s, sel_b_s;

    logic              add_valid_r, flushed_r, orphan_r;
    logic [31:0]       add_a_r, add_b_r, rsp_result_r;
    logic [NREQ-1:0]   rsp_valid_r;
    logic [2:0]        rsp_flags_r;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int offs);
        int sum_v;
        sum_v = (int'(base) + offs) % NREQ;
        return IW'(sum_v);
    endfunction

    // Round-robin search starting one past the last accepted requester.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = last_r;
        found_s     = 1'b0;
        cand_s      = last_r;
        grant_en_s  = rstn && (state_r == ST_RUN) && (count_r < FULL_CNT);
        if (grant_en_s) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand_s = rr_idx(last_r, k);
                if (!found_s && req_valid_i[cand_s]) begin
                    found_s     = 1'b1;
                    grant_idx_s = cand_s;
                end else begin
                    found_s     = found_s;
                end
            end
            if (found_s) begin
                grant_s[grant_idx_s] = 1'b1;
            end else begin
                grant_s = '0;
            end
        end else begin
            grant_s = '0;
        end
    end

    assign req_ready_o = grant_s;
    assign accept_s    = found_s;
    assign head_tag_s  = tag_mem_r[rd_ptr_r];
    assign pop_s       = add_done_i && (count_r != '0);
    assign orphan_s    = add_done_i && (count_r == '0);

    // Operand mux; the grant is one-hot so an AND-OR select suffices.
    always_comb begin
        sel_a_s = 32'h0000_0000;
        sel_b_s = 32'h0000_0000;
        for (int i = 0; i < NREQ; i++) begin
            sel_a_s = sel_a_s | ({32{grant_s[i]}} & req_a_i[i*32 +: 32]);
            sel_b_s = sel_b_s | ({32{grant_s[i]}} & req_b_i[i*32 +: 32]);
        end
    end

    // Response routing, in-flight count and control-state next values.
    always_comb begin
        rsp_onehot_s = '0;
        count_nx_s   = count_r;
        state_nx_s   = state_r;
        if (pop_s) begin
            rsp_onehot_s[head_tag_s] = 1'b1;
        end else begin
            rsp_onehot_s = '0;
        end
        if (accept_s && !pop_s) begin
            count_nx_s = count_r + CW'(1);
        end else if (!accept_s && pop_s) begin
            count_nx_s = count_r - CW'(1);
        end else begin
            count_nx_s = count_r;
        end
        case (state_r)
            ST_RUN: begin
                if (flush_i) state_nx_s = ST_DRAIN;
                else         state_nx_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (count_r == '0) state_nx_s = ST_HALT;
                else               state_nx_s = ST_DRAIN;
            end
            ST_HALT: begin
                if (flush_i)       state_nx_s = ST_HALT;
                else if (resume_i) state_nx_s = ST_RUN;
                else               state_nx_s = ST_HALT;
            end
            default: state_nx_s = ST_RUN;
        endcase
    end

    // Control state, halt indicator and sticky orphan flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r   <= ST_RUN;
            flushed_r <= 1'b0;
            orphan_r  <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            flushed_r <= (state_nx_s == ST_HALT);
            orphan_r  <= orphan_r | orphan_s;
        end
    end

    // Tag FIFO, in-flight count and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            last_r   <= LAST_RST;
            for (int i = 0; i < TAG_DEPTH; i++) tag_mem_r[i] <= '0;
        end else begin
            count_r <= count_nx_s;
            if (accept_s) begin
                tag_mem_r[wr_ptr_r] <= grant_idx_s;
                wr_ptr_r            <= wr_ptr_r + PW'(1);
                last_r              <= grant_idx_s;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
        end
    end

    // Adder issue register: one cycle after each accept.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            add_valid_r <= 1'b0;
            add_a_r     <= 32'h0000_0000;
            add_b_r     <= 32'h0000_0000;
        end else begin
            add_valid_r <= accept_s;
            if (accept_s) begin
                add_a_r <= sel_a_s;
                add_b_r <= sel_b_s;
            end
        end
    end

    // Response register; data holds between pulses, orphans leave it untouched.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rsp_valid_r  <= '0;
            rsp_result_r <= 32'h0000_0000;
            rsp_flags_r  <= 3'b000;
        end else begin
            rsp_valid_r <= rsp_onehot_s;
            if (pop_s) begin
                rsp_result_r <= add_result_i;
                rsp_flags_r  <= {add_overflow_i, add_underflow_i, add_invalid_i};
            end
        end
    end

    assign add_valid_o  = add_valid_r;
    assign add_a_o      = add_a_r;
    assign add_b_o      = add_b_r;
    assign rsp_valid_o  = rsp_valid_r;
    assign rsp_result_o = rsp_result_r;
    assign rsp_flags_o  = rsp_flags_r;
    assign flushed_o    = flushed_r;
    assign orphan_err_o = orphan_r;

`ifdef FP32_ARB_STATS_EN
    logic [15:0] stat_cnt_r [NREQ];

    // Saturating per-requester accept counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NREQ; i++) stat_cnt_r[i] <= 16'h0000;
        end else if (accept_s && (stat_cnt_r[grant_idx_s] != 16'hFFFF)) begin
            stat_cnt_r[grant_idx_s] <= stat_cnt_r[grant_idx_s] + 16'h0001;
        end
    end

    // Flatten counters onto the stats port.
    always_comb begin
        stat_issued_o = '0;
        for (int i = 0; i < NREQ; i++) stat_issued_o[i*16 +: 16] = stat_cnt_r[i];
    end
`endif

endmodule

// File: tb/tb_fp32_add_arbiter.sv
// Bench for fp32_add_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_fp32_add_arbiter;
    localparam int NREQ = 4;
    localparam int TAG_DEPTH = 8;
    localparam int LAT = 3;
    localparam int RUN_S = 0, DRAIN_S = 1, HALT_S = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rstn;
    logic [NREQ-1:0]     req_valid_i;
    logic [NREQ*32-1:0]  req_a_i, req_b_i;
    logic [NREQ-1:0]     req_ready_o;
    logic                add_valid_o;
    logic [31:0]         add_a_o, add_b_o, add_result_i;
    logic                add_done_i, add_overflow_i, add_underflow_i, add_invalid_i;
    logic [NREQ-1:0]     rsp_valid_o;
    logic [31:0]         rsp_result_o;
    logic [2:0]          rsp_flags_o;
    logic                flush_i, resume_i, flushed_o, orphan_err_o;
`ifdef FP32_ARB_STATS_EN
    logic [NREQ*16-1:0]  stat_issued_o;
`endif

    fp32_add_arbiter #(.NREQ(NREQ), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid_i(req_valid_i), .req_a_i(req_a_i), .req_b_i(req_b_i), .req_ready_o(req_ready_o),
        .add_valid_o(add_valid_o), .add_a_o(add_a_o), .add_b_o(add_b_o),
        .add_result_i(add_result_i), .add_done_i(add_done_i), .add_overflow_i(add_overflow_i),
        .add_underflow_i(add_underflow_i), .add_invalid_i(add_invalid_i),
        .rsp_valid_o(rsp_valid_o), .rsp_result_o(rsp_result_o), .rsp_flags_o(rsp_flags_o),
        .flush_i(flush_i), .resume_i(resume_i), .flushed_o(flushed_o), .orphan_err_o(orphan_err_o)
`ifdef FP32_ARB_STATS_EN
        , .stat_issued_o(stat_issued_o)
`endif
    );

    typedef struct { logic [31:0] a; logic [31:0] b; int due; } op_t;
    op_t pend[$];

    int total = 0, bad = 0;
    int cyc = 0;
    int m_state, m_last;
    int m_tags[$];
    int obs_log[$];
    bit log_en, stall, inject_orphan, m_orphan, e_addv, e_flushed;
    logic [NREQ-1:0] e_rsp_valid;
    logic [31:0] e_rsp_res, e_a, e_b;
    logic [2:0] e_rsp_flags;
    int m_stat[NREQ];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stand-in adder: a true FP32 sum for the directed pair, an integer sum otherwise.
    function automatic logic [31:0] stub_sum(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + b;
    endfunction

    function automatic logic [2:0] stub_flags(input logic [31:0] a, input logic [31:0] b);
        return {a[31] & b[31], a[0] ^ b[0], a[1] & b[1]};
    endfunction

    function automatic int model_grant();
        if (!rstn || m_state != RUN_S || m_tags.size() >= TAG_DEPTH) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (req_valid_i[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a_i[i*32 +: 32] = $urandom();
            req_b_i[i*32 +: 32] = $urandom();
        end
    endtask

    task automatic cycle();
        int g, cnt0;
        bit done;
        logic [31:0] res;
        logic [2:0] fl;
        op_t o;
        done = 1'b0; res = 32'h0; fl = 3'b000;
        if (inject_orphan) begin
            done = 1'b1; res = 32'hDEAD_BEEF; fl = 3'b111; inject_orphan = 1'b0;
        end else if (!stall && pend.size() > 0 && pend[0].due <= cyc) begin
            o = pend.pop_front();
            done = 1'b1; res = stub_sum(o.a, o.b); fl = stub_flags(o.a, o.b);
        end
        add_done_i = done; add_result_i = res;
        {add_overflow_i, add_underflow_i, add_invalid_i} = fl;
        @(negedge clk);
        g = model_grant();
        chk("req_ready", req_ready_o, (g >= 0) ? (64'd1 << g) : 64'd0);
        if (log_en) begin
            for (int i = 0; i < NREQ; i++) if (req_ready_o[i] && req_valid_i[i]) obs_log.push_back(i);
        end
        @(posedge clk);
        if (!rstn) begin
            m_state = RUN_S; m_tags.delete(); m_last = NREQ - 1; m_orphan = 1'b0;
            e_rsp_valid = '0; e_rsp_res = 32'h0; e_rsp_flags = 3'b000;
            e_addv = 1'b0; e_a = 32'h0; e_b = 32'h0; e_flushed = 1'b0;
            for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
        end else begin
            cnt0 = m_tags.size();
            e_rsp_valid = '0;
            if (done) begin
                if (cnt0 > 0) begin
                    e_rsp_valid = NREQ'(1 << m_tags.pop_front());
                    e_rsp_res = res; e_rsp_flags = fl;
                end else begin
                    m_orphan = 1'b1;
                end
            end
            if (g >= 0) begin
                m_tags.push_back(g); m_last = g; e_addv = 1'b1;
                e_a = req_a_i[32*g +: 32]; e_b = req_b_i[32*g +: 32];
                if (m_stat[g] < 65535) m_stat[g]++;
            end else begin
                e_addv = 1'b0;
            end
            case (m_state)
                RUN_S:   if (flush_i) m_state = DRAIN_S;
                DRAIN_S: if (cnt0 == 0) m_state = HALT_S;
                HALT_S:  if (!flush_i && resume_i) m_state = RUN_S;
                default: m_state = RUN_S;
            endcase
            e_flushed = (m_state == HALT_S);
        end
        #1;
        cyc++;
        chk("add_valid", add_valid_o, e_addv);
        if (e_addv) begin
            chk("add_a", add_a_o, e_a);
            chk("add_b", add_b_o, e_b);
        end
        chk("rsp_valid", rsp_valid_o, e_rsp_valid);
        chk("rsp_result", rsp_result_o, e_rsp_res);
        chk("rsp_flags", rsp_flags_o, e_rsp_flags);
        chk("flushed", flushed_o, e_flushed);
        chk("orphan", orphan_err_o, m_orphan);
`ifdef FP32_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) chk("stat", stat_issued_o[i*16 +: 16], m_stat[i]);
`endif
        if (add_valid_o) pend.push_back('{a: add_a_o, b: add_b_o, due: cyc + LAT});
    endtask

    task automatic do_reset();
        rstn = 1'b0; cycle(); rstn = 1'b1;
    endtask

    initial begin
        int t0;
        rstn = 1'b0; req_valid_i = '0; req_a_i = '0; req_b_i = '0;
        add_done_i = 1'b0; add_result_i = 32'h0; add_overflow_i = 1'b0; add_underflow_i = 1'b0;
        add_invalid_i = 1'b0; flush_i = 1'b0; resume_i = 1'b0;
        stall = 1'b0; inject_orphan = 1'b0; log_en = 1'b0;
        m_state = RUN_S; m_last = NREQ - 1; m_orphan = 1'b0;

        // Reset with requests pending: no grants, outputs cleared.
        req_valid_i = 4'hF; rand_ops();
        repeat (3) cycle();
        rstn = 1'b1; req_valid_i = '0;
        cycle();

        // Single op from requester 2.
        req_a_i[2*32 +: 32] = 32'h3F80_0000; req_b_i[2*32 +: 32] = 32'h4000_0000;
        req_valid_i = 4'b0100; t0 = cyc;
        cycle();
        req_valid_i = '0;
        chk("single_issue", add_valid_o, 1);
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid_o != '0) break;
            cycle();
        end
        chk("single_latency", cyc - t0, LAT + 2);
        chk("single_rsp_valid", rsp_valid_o, 4'b0100);
        chk("single_rsp_result", rsp_result_o, 32'h4040_0000);
        chk("single_rsp_flags", rsp_flags_o, 3'b000);

        // All four requesters for 8 cycles.
        do_reset();
        obs_log.delete(); log_en = 1'b1; req_valid_i = 4'hF;
        repeat (8) begin rand_ops(); cycle(); end
        log_en = 1'b0; req_valid_i = '0;
        chk("rr_count", obs_log.size(), 8);
        for (int i = 0; i < 8 && i < obs_log.size(); i++) chk("rr_order", obs_log[i], i % 4);
        repeat (12) cycle();

        // Adder stalled: TAG_DEPTH accepts then blocked, first pop re-opens.
        do_reset();
        stall = 1'b1; req_valid_i = 4'hF;
        repeat (10) begin rand_ops(); cycle(); end
        chk("full_noready", req_ready_o, 4'b0000);
        stall = 1'b0;
        cycle();
        chk("pop_regrant", |req_ready_o, 1);
        req_valid_i = '0;
        repeat (20) cycle();

        // Flush with 3 ops in flight, then resume.
        do_reset();
        req_valid_i = 4'b0111; rand_ops();
        repeat (3) cycle();
        req_valid_i = '0; flush_i = 1'b1;
        cycle();
        flush_i = 1'b0; req_valid_i = 4'hF;
        for (int i = 0; i < 30; i++) begin
            if (flushed_o) break;
            cycle();
        end
        chk("flush_halt", flushed_o, 1);
        resume_i = 1'b1;
        cycle();
        resume_i = 1'b0;
        chk("resume_grant", |req_ready_o, 1);
        req_valid_i = '0;
        repeat (12) cycle();

        // Orphan completion with the FIFO empty; reset clears the flag.
        do_reset();
        inject_orphan = 1'b1;
        cycle();
        chk("orphan_set", orphan_err_o, 1);
        chk("orphan_no_rsp", rsp_valid_o, 4'b0000);
        repeat (3) cycle();
        do_reset();
        cycle();
        chk("orphan_cleared", orphan_err_o, 0);

        // Reset mid-operation: late completions become orphans.
        req_valid_i = 4'hF;
        repeat (4) begin rand_ops(); cycle(); end
        req_valid_i = '0;
        do_reset();
        repeat (10) cycle();
        chk("late_orphan", orphan_err_o, 1);
        do_reset();

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            rand_ops();
            req_valid_i = NREQ'($urandom());
            stall = ($urandom_range(0, 7) == 0);
            flush_i = ($urandom_range(0, 39) == 0);
            resume_i = ($urandom_range(0, 9) == 0);
            if (m_tags.size() == 0 && $urandom_range(0, 49) == 0) inject_orphan = 1'b1;
            cycle();
        end
        req_valid_i = '0; flush_i = 1'b0; resume_i = 1'b0; stall = 1'b0;
        repeat (20) cycle();

`ifdef FP32_ARB_STATS_EN
        do_reset();
        req_valid_i = 4'b0010;
        repeat (5) cycle();
        req_valid_i = '0;
        cycle();
        chk("stat_five", stat_issued_o[31:16], 16'd5);
        req_valid_i = 4'b0010;
        repeat (70000 - 5) cycle();
        req_valid_i = '0;
        repeat (8) cycle();
        chk("stat_saturate", stat_issued_o[31:16], 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
